// File: rtl/spi_mst.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : spi_mst
// Function : SPI mode-0 register-access master. Sends a 24-bit command frame,
//            then receives and checks a 24-bit response frame.
// Revision : 1.0
//------------------------------------------------------------------------------
module spi_mst #(
    parameter  int SCLK_DIV    = 2,
    parameter  int CSB_GAP_CYC = 16,
    localparam int REG_AW      = 7,
    localparam int REG_DW      = 8,
    localparam int REG_CRC_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic              i_rd_req,
    input  logic [REG_AW-1:0] i_addr,
    input  logic [REG_DW-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [REG_DW-1:0] o_rdata,
    output logic              o_err,
    output logic [1:0]        o_err_type,
    output logic              o_spi_sclk,
    output logic              o_spi_csb,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso
);

    localparam int FRAME_W = 1 + REG_AW + REG_DW + REG_CRC_W;
    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CSB_GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_GAP  = 3'd2,
        ST_RSP  = 3'd3,
        ST_CHK  = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    // CRC-8, polynomial x^8+x^2+x+1, zero init, MSB first over 16 bits.
    function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [15:0] d);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    state_t              state;
    logic [7:0]          div_cnt;
    logic [7:0]          gap_cnt;
    logic [4:0]          bit_cnt;
    logic                tail;
    logic [FRAME_W-1:0]  tx_sr;
    logic [FRAME_W-1:0]  rx_sr;
    logic                lat_wr;
    logic [REG_AW-1:0]   lat_addr;

    logic [REG_DW-1:0]   cmd_data;
    logic [15:0]         cmd_hi;
    logic [FRAME_W-1:0]  cmd_frame;
    logic                crc_bad;
    logic                id_bad;

    always_comb begin
        cmd_data  = i_wr_req ? i_wdata : '0;
        cmd_hi    = {i_wr_req, i_addr, cmd_data};
        cmd_frame = {cmd_hi, crc16to8_parallel(cmd_hi)};
        crc_bad   = crc16to8_parallel(rx_sr[23:8]) != rx_sr[7:0];
        id_bad    = (rx_sr[22:16] != lat_addr) || (rx_sr[23] != lat_wr);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_spi_csb  <= 1'b1;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_type <= 2'b00;
            o_rdata    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            tail       <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
        end else begin
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_type <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (i_wr_req || i_rd_req) begin
                        lat_wr     <= i_wr_req;
                        lat_addr   <= i_addr;
                        tx_sr      <= cmd_frame;
                        o_spi_mosi <= cmd_frame[FRAME_W-1];
                        o_spi_csb  <= 1'b0;
                        o_busy     <= 1'b1;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        tail       <= 1'b0;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD, ST_RSP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (tail) begin
                            // Trailing half period done: close the frame.
                            tail       <= 1'b0;
                            o_spi_csb  <= 1'b1;
                            o_spi_mosi <= 1'b0;
                            gap_cnt    <= '0;
                            if (state == ST_CMD) begin
                                state <= ST_GAP;
                            end else begin
                                state      <= ST_CHK;
                                o_done     <= 1'b1;
                                o_err      <= crc_bad | id_bad;
                                o_err_type <= {id_bad, crc_bad};
                                if (!lat_wr && !crc_bad && !id_bad)
                                    o_rdata <= rx_sr[15:8];
                            end
                        end else if (!o_spi_sclk) begin
                            o_spi_sclk <= 1'b1;
                            if (state == ST_RSP)
                                rx_sr <= {rx_sr[FRAME_W-2:0], i_spi_miso};
                        end else begin
                            o_spi_sclk <= 1'b0;
                            if (bit_cnt == 5'd23) begin
                                tail <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                if (state == ST_CMD) begin
                                    tx_sr      <= {tx_sr[FRAME_W-2:0], 1'b0};
                                    o_spi_mosi <= tx_sr[FRAME_W-2];
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= ST_RSP;
                        o_spi_csb  <= 1'b0;
                        o_spi_mosi <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        rx_sr      <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                ST_CHK: begin
                    gap_cnt <= '0;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_mst.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_spi_mst
// Function : Self-checking bench for spi_mst with an SPI slave model.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_mst;

    localparam int SCLK_DIV    = 2;
    localparam int CSB_GAP_CYC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       spi_miso = 1'b0;
    logic       busy, done, err, spi_sclk, spi_csb, spi_mosi;
    logic [7:0] rdata;
    logic [1:0] err_type;

    spi_mst #(.SCLK_DIV(SCLK_DIV), .CSB_GAP_CYC(CSB_GAP_CYC)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_req(wr_req), .i_rd_req(rd_req),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
        .o_rdata(rdata), .o_err(err), .o_err_type(err_type),
        .o_spi_sclk(spi_sclk), .o_spi_csb(spi_csb), .o_spi_mosi(spi_mosi),
        .i_spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // CRC as remainder of {d, 8'h00} modulo 0x107.
    function automatic logic [7:0] m_crc(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h107 << (i - 8));
        return r[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor and slave model
    logic [23:0] resp_word = '0;
    logic [23:0] cap = '0;
    logic        mosi_or = 1'b0;
    logic [23:0] f_bits [2];
    int          f_rises [2];
    logic        f_mosi_or [2];
    int          f_gap [2];
    int          frames = 0, rises = 0, gap_len = 0, high_len = 0;
    int          bad_half = 0, sclk_csb_hi = 0, done_cnt = 0, sidx = 0;
    logic        p_csb = 1'b1, p_sclk = 1'b0;

    always @(negedge clk) begin
        if (!spi_csb) begin
            if (p_csb) begin
                cap = '0; rises = 0; mosi_or = 1'b0;
                if (frames < 2) f_gap[frames] = gap_len;
                sidx = 23; spi_miso = resp_word[23];
            end else if (p_sclk && !spi_sclk && sidx > 0) begin
                sidx--; spi_miso = resp_word[sidx];
            end
            if (spi_sclk && !p_sclk) begin
                cap = {cap[22:0], spi_mosi}; rises++;
            end
            mosi_or = mosi_or | spi_mosi;
        end else begin
            if (!p_csb) begin
                if (frames < 2) begin
                    f_bits[frames] = cap; f_rises[frames] = rises; f_mosi_or[frames] = mosi_or;
                end
                frames++; gap_len = 0;
            end
            gap_len++;
            if (spi_sclk) sclk_csb_hi++;
        end
        if (spi_sclk) high_len++;
        else begin
            if (p_sclk && high_len != SCLK_DIV) bad_half++;
            high_len = 0;
        end
        if (done) done_cnt++;
        p_csb = spi_csb; p_sclk = spi_sclk;
    end

    // inject: 0 none, 1 write request during GAP, 2 read request during HOLD
    task automatic run_txn(input string nm, input logic wr, input logic rd,
                           input logic [6:0] a, input logic [7:0] d, input logic [23:0] resp,
                           input logic exp_err, input logic [1:0] exp_type,
                           input logic [7:0] exp_rd, input int inject);
        logic [7:0]  cd;
        logic [23:0] exp_cmd;
        int          k;
        logic        stray;
        cd      = wr ? d : 8'h00;
        exp_cmd = {wr, a, cd, m_crc({wr, a, cd})};
        step();
        resp_word = resp; frames = 0; done_cnt = 0; bad_half = 0; sclk_csb_hi = 0;
        wr_req = wr; rd_req = rd; addr = a; wdata = d;
        step();
        wr_req = 1'b0; rd_req = 1'b0; addr = ~a; wdata = ~d;
        check({nm, " accept_busy"}, busy, 1);
        if (inject == 1) begin
            k = 0;
            while (frames < 1 && k < 1000) begin step(); k++; end
            step();
            wr_req = 1'b1; addr = 7'h7F; wdata = 8'hEE;
            step();
            wr_req = 1'b0;
        end
        k = 0;
        while (!done && k < 3000) begin step(); k++; end
        check({nm, " done_seen"}, done, 1);
        if (!done) return;
        check({nm, " err"}, err, exp_err);
        check({nm, " err_type"}, err_type, exp_type);
        check({nm, " rdata"}, rdata, exp_rd);
        step();
        check({nm, " done_one_cycle"}, done, 0);
        if (inject == 2) begin rd_req = 1'b1; addr = 7'h55; end
        for (int j = 2; j <= CSB_GAP_CYC; j++) begin
            step();
            rd_req = 1'b0;
        end
        check({nm, " busy_in_hold"}, busy, 1);
        step();
        check({nm, " busy_after_hold"}, busy, 0);
        check({nm, " frames"}, frames, 2);
        check({nm, " cmd_bits"}, f_bits[0], exp_cmd);
        check({nm, " cmd_rises"}, f_rises[0], 24);
        check({nm, " rsp_rises"}, f_rises[1], 24);
        check({nm, " rsp_mosi_zero"}, f_mosi_or[1], 0);
        check({nm, " csb_gap"}, f_gap[1], CSB_GAP_CYC);
        check({nm, " sclk_half_period"}, bad_half, 0);
        check({nm, " sclk_csb_high"}, sclk_csb_hi, 0);
        check({nm, " done_count"}, done_cnt, 1);
        if (inject != 0) begin
            stray = 1'b0;
            for (int j = 0; j < 3 * CSB_GAP_CYC; j++) begin
                step();
                stray = stray | busy | ~spi_csb;
            end
            check({nm, " request_ignored"}, stray, 0);
        end
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       rtype;
        logic [6:0] raddr;
        logic [7:0] rdat;
        logic [7:0] crc_flip;
        logic       exp_err;
        logic [1:0] exp_type;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t        tbl [8];
    logic [7:0]  m_rdata;
    logic [23:0] resp;
    int          k;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 7'h05, 8'hA5, 1'b1, 7'h05, 8'hA5, 8'h00, 1'b0, 2'b00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 7'h12, 8'h00, 1'b0, 7'h12, 8'h3C, 8'h00, 1'b0, 2'b00, 8'h3C};
        tbl[2] = '{1'b0, 1'b1, 7'h12, 8'h00, 1'b0, 7'h12, 8'h77, 8'h01, 1'b1, 2'b01, 8'h3C};
        tbl[3] = '{1'b1, 1'b0, 7'h05, 8'hA5, 1'b1, 7'h06, 8'hA5, 8'h00, 1'b1, 2'b10, 8'h3C};
        tbl[4] = '{1'b1, 1'b0, 7'h05, 8'hA5, 1'b0, 7'h05, 8'hA5, 8'h00, 1'b1, 2'b10, 8'h3C};
        tbl[5] = '{1'b1, 1'b1, 7'h33, 8'h5A, 1'b1, 7'h33, 8'h5A, 8'h00, 1'b0, 2'b00, 8'h3C};
        tbl[6] = '{1'b0, 1'b1, 7'h44, 8'h00, 1'b0, 7'h45, 8'h10, 8'h80, 1'b1, 2'b11, 8'h3C};
        tbl[7] = '{1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 7'h7F, 8'hC3, 8'h00, 1'b0, 2'b00, 8'hC3};

        step();
        check("reset_bus", {spi_csb, spi_sclk, spi_mosi}, 3'b100);
        check("reset_status", {busy, done, err, err_type, rdata}, 13'h0);
        step();
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            resp = {tbl[i].rtype, tbl[i].raddr, tbl[i].rdat,
                    m_crc({tbl[i].rtype, tbl[i].raddr, tbl[i].rdat}) ^ tbl[i].crc_flip};
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata,
                    resp, tbl[i].exp_err, tbl[i].exp_type, tbl[i].exp_rdata, 0);
        end

        resp = {1'b0, 7'h21, 8'h99, m_crc({1'b0, 7'h21, 8'h99})};
        run_txn("gap_req", 1'b0, 1'b1, 7'h21, 8'h00, resp, 1'b0, 2'b00, 8'h99, 1);
        resp = {1'b1, 7'h0A, 8'h0B, m_crc({1'b1, 7'h0A, 8'h0B})};
        run_txn("hold_req", 1'b1, 1'b0, 7'h0A, 8'h0B, resp, 1'b0, 2'b00, 8'h99, 2);

        // Reset in the middle of the command frame
        step();
        frames = 0; done_cnt = 0;
        wr_req = 1'b1; addr = 7'h2A; wdata = 8'h11;
        step();
        wr_req = 1'b0;
        k = 0;
        while (rises < 10 && k < 500) begin step(); k++; end
        check("abort_reached_bit10", rises, 10);
        #1 rst = 1'b1;
        #1;
        check("abort_csb_sclk", {spi_csb, spi_sclk}, 2'b10);
        check("abort_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        for (int j = 0; j < 20; j++) step();
        check("abort_no_done", done_cnt, 0);
        resp = {1'b0, 7'h12, 8'h3C, m_crc({1'b0, 7'h12, 8'h3C})};
        run_txn("after_abort", 1'b0, 1'b1, 7'h12, 8'h00, resp, 1'b0, 2'b00, 8'h3C, 0);
        m_rdata = 8'h3C;

        for (int n = 0; n < 16; n++) begin
            logic       rwr, rrd;
            logic [6:0] ra;
            logic [7:0] rd8, rdat;
            logic [1:0] t;
            int         f;
            rrd  = 1'($urandom_range(0, 1));
            rwr  = rrd ? 1'($urandom_range(0, 1)) : 1'b1;
            ra   = 7'($urandom);
            rd8  = 8'($urandom);
            rdat = 8'($urandom);
            f    = $urandom_range(0, 3);
            resp = {rwr, ra, rdat, m_crc({rwr, ra, rdat})};
            case (f)
                1: resp[7:0]   = resp[7:0] ^ 8'(1 << $urandom_range(0, 7));
                2: resp[22:16] = resp[22:16] ^ 7'($urandom_range(1, 127));
                3: resp[23]    = ~resp[23];
                default: ;
            endcase
            if (f >= 2 && $urandom_range(0, 1) == 1)
                resp[7:0] = m_crc(resp[23:8]);
            t[0] = m_crc(resp[23:8]) != resp[7:0];
            t[1] = (resp[22:16] != ra) || (resp[23] != rwr);
            if (!rwr && t == 2'b00) m_rdata = resp[15:8];
            run_txn($sformatf("rnd%0d", n), rwr, rrd, ra, rd8, resp, |t, t, m_rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_mst.md
SPI_MST -- requirements
Module: spi_mst

Interface
REQ-001 The block SHALL take parameter SCLK_DIV, default 2: SCLK half-period in i_clk cycles, legal range 1..255.
REQ-002 The block SHALL take parameter CSB_GAP_CYC, default 16: minimum CSB-high i_clk cycles between frames, legal range 1..255.
REQ-003 REG_AW=7, REG_DW=8 and REG_CRC_W=8 SHALL come from com_param.svh.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; ports SHALL be as follows.
- i_clk  in  1  system clock, all logic on posedge
- i_rst  in  1  async active-high reset
- i_wr_req  in  1  write request pulse, sampled only in IDLE
- i_rd_req  in  1  read request pulse, sampled only in IDLE
- i_addr  in  REG_AW  register address
- i_wdata  in  REG_DW  write data
- o_busy  out  1  high from request accept until return to IDLE
- o_done  out  1  one-cycle transaction-complete pulse
- o_rdata  out  REG_DW  last good read data
- o_err  out  1  one-cycle pulse with o_done on response failure
- o_err_type  out  2  bit0 = CRC mismatch, bit1 = addr/type mismatch; valid with o_err
- o_spi_sclk  out  1  SPI clock, idles low
- o_spi_csb  out  1  chip select, low active
- o_spi_mosi  out  1  master out
- i_spi_miso  in  1  slave out, already synchronous to i_clk

Function
REQ-005 FSM states SHALL be IDLE, CMD, GAP, RSP, CHK and HOLD, in that fixed sequence: IDLE->CMD on accept; CMD->GAP after 24 bits; GAP->RSP after CSB_GAP_CYC; RSP->CHK after 24 bits; CHK->HOLD after 1 cycle; HOLD->IDLE after CSB_GAP_CYC.
REQ-006 Accept SHALL occur only in IDLE; if i_wr_req and i_rd_req are both high, the write wins and the read is dropped; requests outside IDLE SHALL be ignored, not queued.
REQ-007 On accept, addr, wdata and the wr flag SHALL be latched; later input changes SHALL have no effect.
REQ-008 Command frame, MSB first, SHALL be {wr, addr[6:0], data[7:0], crc[7:0]}; data = wdata for a write, 0x00 for a read; crc = crc16to8_parallel({cmd, data}).
REQ-009 SPI mode 0 SHALL be used: o_spi_csb falls and bit 23 drives on the same i_clk edge; the first SCLK rise follows SCLK_DIV cycles later; MOSI changes only on SCLK falls; 24 rising edges per frame.
REQ-010 o_spi_csb SHALL rise SCLK_DIV cycles after the 24th SCLK fall, with SCLK low; SCLK SHALL never toggle while CSB is high.
REQ-011 In RSP, o_spi_mosi SHALL be held 0; i_spi_miso SHALL be sampled on the i_clk cycle that drives each SCLK rise, shifted MSB first into a 24-bit register.
REQ-012 The response {type, raddr[6:0], rdata[7:0], rcrc[7:0]} SHALL be checked in CHK.
- CRC error if crc16to8_parallel({type, raddr, rdata}) != rcrc.
- Mismatch error if raddr != latched addr, or type != latched wr (1 = write ack, 0 = read ack).
REQ-013 In CHK, o_done SHALL pulse; o_err and o_err_type SHALL pulse in the same cycle when any check fails, and both error bits SHALL be set when both checks fail.
REQ-014 o_rdata SHALL update in CHK only for a read with no error; otherwise it SHALL hold.
REQ-015 o_busy SHALL be high in every state except IDLE, including HOLD.
REQ-016 The SCLK divider SHALL be reset on entry to CMD and RSP; bit counters SHALL be 5 bits and count 0..23 with no wrap beyond.

Reset
REQ-017 While i_rst is high, the block SHALL hold these values asynchronously: state IDLE, o_spi_csb=1, o_spi_sclk=0, o_spi_mosi=0, o_busy=0, o_done=0, o_err=0, o_err_type=0, o_rdata=0x00, all counters and shift registers 0.
REQ-018 Reset during a frame SHALL abort it immediately, with CSB high in the same cycle; no o_done SHALL be issued for the aborted transaction.

Verification
REQ-019 Bench scenarios:
- Write addr 0x05, data 0xA5, SCLK_DIV=2: MOSI = 0x85, 0xA5, crc(0x85A5); 24 SCLK pulses of 4 cycles each; good response gives o_done=1, o_err=0.
- Read addr 0x12; slave response {0, 0x12, 0x3C, crc}: o_rdata=0x3C, o_err=0, MOSI all 0 in RSP.
- Read response with one rcrc bit flipped: o_err=1, o_err_type=01, o_rdata unchanged.
- Write response with raddr=0x06 and a correct CRC: o_err_type=10; type=0 on a write response also gives 10.
- i_wr_req and i_rd_req high together in IDLE: only the write is sent; a request pulsed during GAP is ignored; a new request is accepted only after HOLD.
- i_rst asserted at bit 10 of CMD: CSB=1 and SCLK=0 at once; a following read completes normally.
